inst_ram_seq: RTL

- Writable, parametrised instruction memory with a built-in fetch sequencer. It supersedes the fixed 256x32 case-ROM.
- A host streams a program into on-chip RAM. The block then replays it to the PE array as a timed instruction stream, with loop repeat, stall and abort.
- Sits between the config/host interface and the PE-array decode stage.

---
 rtl/inst_ram_seq_pkg.sv | 13 +
 rtl/inst_ram_seq_bram.sv | 34 +++
 rtl/inst_ram_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_ram_seq_pkg.sv
// inst_ram_seq_pkg: shared widths and sequencer state encodings
// for the writable instruction RAM and its fetch sequencer.
package inst_ram_seq_pkg;

   localparam int INST_WIDTH = 16;
   localparam int DEF_DEPTH  = 256;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/inst_ram_seq_bram.sv
// inst_ram_seq_bram: simple dual-port RAM, one write port and one
// registered read port, shaped to map onto a block RAM.
module inst_ram_seq_bram #(
   parameter int W     = 32,
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   // write port; contents survive reset
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // registered read; holds its value while re_i is low
   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_ram_seq.sv
// inst_ram_seq: host-loaded instruction RAM that replays the program
// as a timed stream with loop repeat, stall and abort.
module inst_ram_seq
   import inst_ram_seq_pkg::*;
#(
   parameter int INST_W  = 2*INST_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int LOOP_W  = 8,
   parameter int OUT_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_start,
   input  logic [ADDR_W:0]   ld_len,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [INST_W-1:0] ld_data,
   output logic              ld_done,
   input  logic              run_start,
   input  logic [LOOP_W-1:0] run_loops,
   input  logic              stall,
   input  logic              abort,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              run_done,
   output logic              busy
);

   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   ld_len_q, ld_len_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [LOOP_W-1:0] pass_q, pass_d;
   logic              ld_done_q, ld_done_d;
   logic              we;
   logic              ld_ok, wr_last, pc_last;
   logic              issue, last_issue;
   logic              v1_q, last1_q;
   logic [ADDR_W-1:0] pc1_q;
   logic [INST_W-1:0] rdata;
   logic              vo, lasto;

   assign ld_ok = ld_start && (ld_len != '0) && (ld_len <= DEPTH_N);
   assign wr_last = ({1'b0, wr_ptr_q} == ld_len_q - LEN_ONE);
   assign pc_last = ({1'b0, pc_q} == prog_len_q - LEN_ONE);
   assign issue = (state_q == S_RUN) && !stall && !abort;
   assign last_issue = issue && pc_last && (pass_q == '0);

   // next-state: load pointer, fetch pc, pass counter, FSM
   always_comb begin
      state_d    = state_q;
      ld_len_d   = ld_len_q;
      prog_len_d = prog_len_q;
      wr_ptr_d   = wr_ptr_q;
      pc_d       = pc_q;
      pass_d     = pass_q;
      ld_done_d  = 1'b0;
      we         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (ld_ok) begin
               state_d  = S_LOAD;
               ld_len_d = ld_len;
               wr_ptr_d = '0;
            end else if (run_start && prog_len_q != '0) begin
               state_d = S_RUN;
               pc_d    = '0;
               pass_d  = run_loops;
            end
         end
         S_LOAD: begin
            if (ld_valid) begin
               we       = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (wr_last) begin
                  prog_len_d = ld_len_q;
                  ld_done_d  = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         S_RUN: begin
            if (!stall) begin
               if (!pc_last) begin
                  pc_d = pc_q + ADDR_W'(1);
               end else if (pass_q != '0) begin
                  pc_d   = '0;
                  pass_d = pass_q - LOOP_W'(1);
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!v1_q && !vo) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d    = S_IDLE;
         prog_len_d = prog_len_q;
         ld_done_d  = 1'b0;
         we         = 1'b0;
      end
   end

   // control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ld_len_q   <= '0;
         prog_len_q <= '0;
         wr_ptr_q   <= '0;
         pc_q       <= '0;
         pass_q     <= '0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_len_q   <= ld_len_d;
         prog_len_q <= prog_len_d;
         wr_ptr_q   <= wr_ptr_d;
         pc_q       <= pc_d;
         pass_q     <= pass_d;
         ld_done_q  <= ld_done_d;
      end
   end

   inst_ram_seq_bram #(
      .W     (INST_W),
      .DEPTH (DEPTH),
      .AW    (ADDR_W)
   ) u_bram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (ld_data),
      .re_i    (issue),
      .raddr_i (pc_q),
      .rdata_o (rdata)
   );

   // read stage: pc and end-of-run flag travel with the RAM read
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         pc1_q   <= '0;
         last1_q <= 1'b0;
      end else if (abort) begin
         v1_q    <= 1'b0;
         last1_q <= 1'b0;
      end else if (!stall) begin
         v1_q    <= issue;
         pc1_q   <= pc_q;
         last1_q <= last_issue;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic              vo_q, lasto_q;
         logic [INST_W-1:0] do_q;
         logic [ADDR_W-1:0] pco_q;
         // optional output register, frozen by stall
         always_ff @(posedge clk) begin
            if (rst) begin
               vo_q    <= 1'b0;
               lasto_q <= 1'b0;
               do_q    <= '0;
               pco_q   <= '0;
            end else if (abort) begin
               vo_q    <= 1'b0;
               lasto_q <= 1'b0;
            end else if (!stall) begin
               vo_q    <= v1_q;
               lasto_q <= last1_q;
               do_q    <= rdata;
               pco_q   <= pc1_q;
            end
         end
         assign vo       = vo_q;
         assign lasto    = lasto_q;
         assign inst_out = do_q;
         assign inst_pc  = pco_q;
      end else begin : g_noreg
         assign vo       = v1_q;
         assign lasto    = last1_q;
         assign inst_out = rdata;
         assign inst_pc  = pc1_q;
      end
   endgenerate

   // a stalled last word is still on offer; flag it once, when taken
   assign run_done   = vo && lasto && !stall && !abort;
   assign inst_valid = vo;
   assign ld_ready   = (state_q == S_LOAD) && !abort;
   assign ld_done    = ld_done_q;
   assign busy       = (state_q != S_IDLE) || v1_q || vo;

endmodule
